fib_rr_scheduler: RTL and testbench

//  Shares one iterative Fibonacci engine (one add per cycle) between NREQ requesters.
//  A round-robin arbiter grants one job at a time and runs the iteration to completion.
//  It then returns the result tagged with the requester index.

---
 rtl/fib_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_fib_rr_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fib_rr_scheduler.sv
// Round-robin scheduler sharing one iterative Fibonacci engine (F(n+2), one add per cycle) among NREQ requesters.
// Optional carry/overflow reporting is compiled in with FIB_OVF_DETECT_EN.
module fib_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int W    = 32,
   parameter int NW   = 4,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*NW-1:0] req_n,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              done,
   output logic [IDW-1:0]    done_id,
   output logic [W-1:0]      result
`ifdef FIB_OVF_DETECT_EN
   ,output logic             ovf
`endif
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  id;
   logic [NW-1:0]   nl;
   logic [NW-1:0]   cnt;
   logic [W-1:0]    f;
   logic [W-1:0]    c;

   logic            any_req;
   logic [IDW-1:0]  winner;

`ifdef FIB_OVF_DETECT_EN
   logic            sticky;
   logic [W:0]      sum_ext;
   assign sum_ext = {1'b0, f} + {1'b0, c};
`endif

   // Search starts one past the last winner so every requester is reached within NREQ jobs.
   always_comb begin
      // NOTE: defaults first so no path leaves any_req/winner unassigned (no latch).
      any_req = 1'b0;
      winner  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any_req && req[(int'(rr_ptr) + k) % NREQ]) begin
            any_req = 1'b1;
            winner  = IDW'((int'(rr_ptr) + k) % NREQ);
         end
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rr_ptr  <= IDW'(NREQ - 1);
         id      <= '0;
         nl      <= '0;
         cnt     <= '0;
         f       <= '0;
         c       <= '0;
         grant   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         result  <= '0;
`ifdef FIB_OVF_DETECT_EN
         sticky  <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         grant <= '0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               busy <= any_req;
               if (any_req) begin
                  grant  <= NREQ'(1) << winner;
                  rr_ptr <= winner;
                  id     <= winner;
                  nl     <= req_n[int'(winner)*NW +: NW];
                  f      <= W'(1);
                  c      <= W'(1);
                  cnt    <= '0;
`ifdef FIB_OVF_DETECT_EN
                  sticky <= 1'b0;
`endif
                  state  <= CALC;
               end
            end
            CALC: begin
               busy <= 1'b1;
               if (cnt == nl) begin
                  state <= DONE;
               end else begin
`ifdef FIB_OVF_DETECT_EN
                  f      <= sum_ext[W-1:0];
                  sticky <= sticky | sum_ext[W];
`else
                  f      <= f + c;
`endif
                  c      <= f;
                  cnt    <= cnt + 1'b1;
               end
            end
            DONE: begin
               busy    <= 1'b1;
               done    <= 1'b1;
               result  <= f;
               done_id <= id;
`ifdef FIB_OVF_DETECT_EN
               ovf     <= sticky;
`endif
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_rr_scheduler.sv
// Directed bench for fib_rr_scheduler: expected jobs queued when requests are driven, checked at each done.
// A second W=8 instance covers wrap-around and, with FIB_OVF_DETECT_EN, the ovf flag.
module tb_fib_rr_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int NW   = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*NW-1:0]   req_n;
   logic [NREQ-1:0]      grant;
   logic                 busy;
   logic                 done;
   logic [1:0]           done_id;
   logic [W-1:0]         result;

   logic [NREQ-1:0]      req8;
   logic [NREQ*NW-1:0]   req_n8;
   logic [NREQ-1:0]      grant8;
   logic                 busy8;
   logic                 done8;
   logic [1:0]           done_id8;
   logic [7:0]           result8;
`ifdef FIB_OVF_DETECT_EN
   logic                 ovf;
   logic                 ovf8;
`endif

   fib_rr_scheduler #(.NREQ(NREQ), .W(W), .NW(NW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_n(req_n), .grant(grant), .busy(busy),
      .done(done), .done_id(done_id), .result(result)
`ifdef FIB_OVF_DETECT_EN
      , .ovf(ovf)
`endif
   );

   fib_rr_scheduler #(.NREQ(NREQ), .W(8), .NW(NW)) dut8 (
      .clk(clk), .reset(reset), .req(req8), .req_n(req_n8), .grant(grant8), .busy(busy8),
      .done(done8), .done_id(done_id8), .result(result8)
`ifdef FIB_OVF_DETECT_EN
      , .ovf(ovf8)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      int          n;
      logic [W-1:0] res;
   } job_t;

   job_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   last_done = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int id, input int n, input logic [W-1:0] res);
      job_t j;
      req_n[id*NW +: NW] = NW'(n);
      req[id] = 1'b1;
      j.id = id; j.n = n; j.res = res;
      exp_q.push_back(j);
   endtask

   // Serves the job at the head of the scoreboard; optionally drops its req at done.
   task automatic serve(input bit drop, input bit gap_chk);
      job_t j;
      bit   seen;
      int   gc;
      j = exp_q.pop_front();
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         if (grant != '0) seen = 1'b1;
      end
      check($sformatf("grant_seen_id%0d", j.id), 64'(seen), 64'd1);
      gc = cyc;
      check($sformatf("grant_onehot_id%0d", j.id), 64'(grant), 64'(4'b0001 << j.id));
      check("busy_at_grant", 64'(busy), 64'd1);
      if (gap_chk) check("grant_after_done_gap", 64'(gc), 64'(last_done + 1));
      tick();
      check("grant_pulse", 64'(grant), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (done) seen = 1'b1;
         else tick();
      end
      check($sformatf("done_seen_id%0d", j.id), 64'(seen), 64'd1);
      last_done = cyc;
      check($sformatf("latency_n%0d", j.n), 64'(cyc - gc), 64'(j.n + 2));
      check("done_id", 64'(done_id), 64'(j.id));
      check($sformatf("result_n%0d", j.n), 64'(result), 64'(j.res));
      check("busy_at_done", 64'(busy), 64'd1);
      if (drop) req[j.id] = 1'b0;
   endtask

   task automatic run8(input int n, input logic [7:0] res, input logic ov);
      bit seen;
      req_n8[NW-1:0] = NW'(n);
      req8[0] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         if (done8) seen = 1'b1;
      end
      req8 = '0;
      check($sformatf("w8_done_n%0d", n), 64'(seen), 64'd1);
      check($sformatf("w8_result_n%0d", n), 64'(result8), 64'(res));
`ifdef FIB_OVF_DETECT_EN
      check($sformatf("w8_ovf_n%0d", n), 64'(ovf8), 64'(ov));
`else
      if (ov) begin end
`endif
      tick();
   endtask

   initial begin
      bit seen;
      int npulse;
      reset = 1'b1; req = '0; req_n = '0; req8 = '0; req_n8 = '0;
      repeat (3) tick();
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done_id", 64'(done_id), 64'd0);
      check("rst_result", 64'(result), 64'd0);
`ifdef FIB_OVF_DETECT_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif
      reset = 1'b0;

      // Single jobs, including n=0 and the maximum n.
      set_req(0, 5, 13);
      serve(1, 0);
      set_req(2, 0, 1);
      serve(1, 0);
      set_req(2, 15, 1597);
      serve(1, 0);
      repeat (3) tick();
      check("held_result", 64'(result), 64'd1597);
      check("held_done_id", 64'(done_id), 64'd2);
      check("idle_busy", 64'(busy), 64'd0);

      // All four at once from reset, then 3 and 0 together.
      reset = 1'b1; tick(); reset = 1'b0;
      set_req(0, 1, 2); set_req(1, 2, 3); set_req(2, 3, 5); set_req(3, 4, 8);
      repeat (4) serve(1, 0);
      set_req(0, 2, 3); set_req(3, 1, 2);
      serve(1, 0);
      serve(1, 0);

      // Two requesters held continuously alternate with one gap cycle.
      set_req(1, 3, 5); set_req(3, 6, 21);
      exp_q.push_back('{1, 3, 32'd5});
      exp_q.push_back('{3, 6, 32'd21});
      serve(0, 0);
      serve(0, 1);
      serve(0, 1);
      serve(0, 1);
      req = '0;

      // Reset during a long job: no done, outputs cleared, pointer restored.
      req_n[2*NW +: NW] = 4'd15; req[2] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         if (grant != '0) seen = 1'b1;
      end
      check("t5_grant", 64'(grant), 64'b0100);
      repeat (5) tick();
      reset = 1'b1; req = '0;
      tick();
      check("t5_rst_grant", 64'(grant), 64'd0);
      check("t5_rst_done", 64'(done), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_done_id", 64'(done_id), 64'd0);
      check("t5_rst_result", 64'(result), 64'd0);
      reset = 1'b0;
      npulse = 0;
      repeat (25) begin
         tick();
         if (done) npulse++;
      end
      check("t5_no_done", 64'(npulse), 64'd0);
      set_req(0, 2, 3); set_req(3, 2, 3);
      serve(1, 0);
      serve(1, 0);

      // Narrow instance: last non-wrapping and first wrapping n.
      run8(11, 8'd233, 1'b0);
      run8(12, 8'd121, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
